// File: rtl/che_hist_sch_if.sv
// Pixel-stream and histogram-kernel command bundle for che_hist_sch.
// CHE_HIST_SCH_PERF_EN adds the stall_cnt_o performance counter.
interface che_hist_sch_if #(
    parameter int TILE_X_NUM = 8,
    parameter int TILE_Y_NUM = 8,
    parameter int PIX_WD     = 8
);
    localparam int TROW_WD = (TILE_Y_NUM > 1) ? $clog2(TILE_Y_NUM) : 1;

    logic                  sof_i;
    logic                  pix_vld_i;
    logic [PIX_WD-1:0]     pix_dat_i;
    logic                  pix_rdy_o;
    logic                  dn_rdy_i;
    logic                  wr_en_o;
    logic [TILE_X_NUM-1:0] wr_addr_o;
    logic [PIX_WD-1:0]     dat_o;
    logic                  rd_en_o;
    logic [TILE_X_NUM-1:0] rd_addr_o;
    logic                  rd_double_flg_o;
    logic                  cl_en_o;
    logic [TROW_WD-1:0]    trow_o;
    logic                  frame_done_o;
    logic                  err_o;
`ifdef CHE_HIST_SCH_PERF_EN
    logic [15:0]           stall_cnt_o;
`endif

    modport master (
        input  sof_i, pix_vld_i, pix_dat_i, dn_rdy_i,
        output pix_rdy_o, wr_en_o, wr_addr_o, dat_o, rd_en_o, rd_addr_o,
               rd_double_flg_o, cl_en_o, trow_o, frame_done_o, err_o
`ifdef CHE_HIST_SCH_PERF_EN
        , output stall_cnt_o
`endif
    );

    modport slave (
        output sof_i, pix_vld_i, pix_dat_i, dn_rdy_i,
        input  pix_rdy_o, wr_en_o, wr_addr_o, dat_o, rd_en_o, rd_addr_o,
               rd_double_flg_o, cl_en_o, trow_o, frame_done_o, err_o
`ifdef CHE_HIST_SCH_PERF_EN
        , input stall_cnt_o
`endif
    );
endinterface

// File: rtl/che_hist_sch.sv
// CLAHE tile-histogram sequencer: pixel writes, paired tile reads, tile clears.
// Optional macro CHE_HIST_SCH_PERF_EN enables the 16-bit stall counter.
module che_hist_sch #(
    parameter int TILE_X_NUM = 8,
    parameter int TILE_Y_NUM = 8,
    parameter int TILE_SIZ   = 64,
    parameter int PIX_WD     = 8
) (
    input  logic           clk,
    input  logic           rstn,
    che_hist_sch_if.master bus
);
    localparam int TX_WD   = (TILE_X_NUM > 1) ? $clog2(TILE_X_NUM) : 1;
    localparam int PX_WD   = (TILE_SIZ > 1) ? $clog2(TILE_SIZ) : 1;
    localparam int TROW_WD = (TILE_Y_NUM > 1) ? $clog2(TILE_Y_NUM) : 1;

    typedef enum logic [2:0] {IDLE, ACC, DRAIN, READ, CLEAR} state_t;

    state_t                state, state_nxt;
    logic [TX_WD-1:0]      tx;
    logic [PX_WD-1:0]      px;
    logic [PX_WD-1:0]      y;
    logic [TX_WD-1:0]      cl_cnt;
    logic [TILE_X_NUM-1:0] rd_addr;
    logic [TROW_WD-1:0]    trow;
    logic                  frame_done;
    logic                  err;
    logic                  wr_en;
    logic [TILE_X_NUM-1:0] wr_addr;
    logic [PIX_WD-1:0]     dat;

    logic pix_rdy, rd_en, rd_dbl, cl_en;
    logic accept, sof_ok, tx_last, px_last, y_last, rd_last, cl_last, trow_last;

    // x is kept as tile index + in-tile offset so wr_addr needs no divider
    assign tx_last   = (tx == TX_WD'(TILE_X_NUM - 1));
    assign px_last   = (px == PX_WD'(TILE_SIZ - 1));
    assign y_last    = (y == PX_WD'(TILE_SIZ - 1));
    assign cl_last   = (cl_cnt == TX_WD'(TILE_X_NUM - 1));
    assign trow_last = (trow == TROW_WD'(TILE_Y_NUM - 1));
    assign rd_last   = (32'(rd_addr) + 32'd2 >= 32'(TILE_X_NUM));
    assign accept    = bus.pix_vld_i && pix_rdy;
    // a start pulse coinciding with frame_done is treated as mid-frame
    assign sof_ok    = bus.sof_i && (state == IDLE) && !frame_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (sof_ok) state_nxt = ACC;
            ACC:   if (accept && px_last && tx_last && y_last) state_nxt = DRAIN;
            DRAIN: state_nxt = READ;
            READ:  if (bus.dn_rdy_i && rd_last) state_nxt = CLEAR;
            CLEAR: if (cl_last) state_nxt = trow_last ? IDLE : ACC;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pix_rdy = 1'b0;
        rd_en   = 1'b0;
        rd_dbl  = 1'b0;
        cl_en   = 1'b0;
        unique case (state)
            ACC:   pix_rdy = 1'b1;
            READ: begin
                rd_en  = bus.dn_rdy_i;
                rd_dbl = (32'(rd_addr) + 32'd1 < 32'(TILE_X_NUM));
            end
            CLEAR: cl_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx         <= '0;
            px         <= '0;
            y          <= '0;
            trow       <= '0;
            cl_cnt     <= '0;
            rd_addr    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            dat        <= '0;
        end else begin
            if (sof_ok) begin
                tx   <= '0;
                px   <= '0;
                y    <= '0;
                trow <= '0;
            end else if (accept) begin
                if (px_last) begin
                    px <= '0;
                    if (tx_last) begin
                        tx <= '0;
                        y  <= y_last ? '0 : y + 1'b1;
                    end else begin
                        tx <= tx + 1'b1;
                    end
                end else begin
                    px <= px + 1'b1;
                end
            end

            wr_en <= accept;
            if (accept) begin
                wr_addr <= TILE_X_NUM'(tx);
                dat     <= bus.pix_dat_i;
            end

            if (rd_en) rd_addr <= rd_last ? '0 : rd_addr + TILE_X_NUM'(2);

            if (cl_en) begin
                cl_cnt <= cl_last ? '0 : cl_cnt + 1'b1;
                if (cl_last && !trow_last) trow <= trow + 1'b1;
            end
            frame_done <= cl_en && cl_last && trow_last;

            if (bus.sof_i) err <= !sof_ok;
        end
    end

`ifdef CHE_HIST_SCH_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                                stall_cnt <= '0;
        else if (sof_ok)                                          stall_cnt <= '0;
        else if (bus.pix_vld_i && !pix_rdy && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.stall_cnt_o = stall_cnt;
`endif

    assign bus.pix_rdy_o       = pix_rdy;
    assign bus.wr_en_o         = wr_en;
    assign bus.wr_addr_o       = wr_addr;
    assign bus.dat_o           = dat;
    assign bus.rd_en_o         = rd_en;
    assign bus.rd_addr_o       = rd_addr;
    assign bus.rd_double_flg_o = rd_dbl;
    assign bus.cl_en_o         = cl_en;
    assign bus.trow_o          = trow;
    assign bus.frame_done_o    = frame_done;
    assign bus.err_o           = err;
endmodule

// File: tb/tb_che_hist_sch.sv
// Directed bench: dut_a is 4x2 tiles of 4 px, dut_b is 5x1 tiles of 2 px.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_che_hist_sch;
    logic clk = 1'b0;
    logic rstn;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    che_hist_sch_if #(.TILE_X_NUM(4), .TILE_Y_NUM(2), .PIX_WD(8)) a ();
    che_hist_sch_if #(.TILE_X_NUM(5), .TILE_Y_NUM(1), .PIX_WD(8)) b ();

    che_hist_sch #(.TILE_X_NUM(4), .TILE_Y_NUM(2), .TILE_SIZ(4), .PIX_WD(8))
        dut_a (.clk(clk), .rstn(rstn), .bus(a));
    che_hist_sch #(.TILE_X_NUM(5), .TILE_Y_NUM(1), .TILE_SIZ(2), .PIX_WD(8))
        dut_b (.clk(clk), .rstn(rstn), .bus(b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int mode, input int i);
        if (mode == 0)      return 8'd7;
        else if (mode == 1) return 8'(i * 5 + 1);
        else                return 8'(255 - i);
    endfunction

    // One 16x4 tile row into dut_a; returns at the DRAIN cycle.
    task automatic a_row(input int mode);
        for (int i = 0; i < 64; i++) begin
            if (i > 0) begin
                chk("a_wr_en", 32'(a.wr_en_o), 32'd1);
                chk("a_wr_addr", 32'(a.wr_addr_o), 32'(((i - 1) % 16) / 4));
                chk("a_dat", 32'(a.dat_o), 32'(pv(mode, i - 1)));
            end
            if (mode == 0 && i == 21) chk("a_err_mid", 32'(a.err_o), 32'd1);
            chk("a_pix_rdy_acc", 32'(a.pix_rdy_o), 32'd1);
            a.pix_vld_i = 1'b1;
            a.pix_dat_i = pv(mode, i);
            a.sof_i     = (mode == 0 && i == 20);
            @(negedge clk);
        end
        a.pix_vld_i = 1'b0;
        a.sof_i     = 1'b0;
        chk("a_drain_wr_en", 32'(a.wr_en_o), 32'd1);
        chk("a_drain_wr_addr", 32'(a.wr_addr_o), 32'd3);
        chk("a_drain_dat", 32'(a.dat_o), 32'(pv(mode, 63)));
        chk("a_drain_rdy", 32'(a.pix_rdy_o), 32'd0);
        chk("a_drain_rd_en", 32'(a.rd_en_o), 32'd0);
    endtask

    task automatic a_reads();
        @(negedge clk);
        chk("a_rd0_en", 32'(a.rd_en_o), 32'd1);
        chk("a_rd0_addr", 32'(a.rd_addr_o), 32'd0);
        chk("a_rd0_dbl", 32'(a.rd_double_flg_o), 32'd1);
        chk("a_rd0_wr_en", 32'(a.wr_en_o), 32'd0);
        @(negedge clk);
        chk("a_rd1_en", 32'(a.rd_en_o), 32'd1);
        chk("a_rd1_addr", 32'(a.rd_addr_o), 32'd2);
        chk("a_rd1_dbl", 32'(a.rd_double_flg_o), 32'd1);
    endtask

    task automatic a_clear(input logic [31:0] trow_exp);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("a_cl_en", 32'(a.cl_en_o), 32'd1);
            chk("a_cl_rd_en", 32'(a.rd_en_o), 32'd0);
            chk("a_cl_trow", 32'(a.trow_o), trow_exp);
        end
        @(negedge clk);
        chk("a_cl_done", 32'(a.cl_en_o), 32'd0);
    endtask

    initial begin
        rstn = 1'b1;
        a.sof_i = 1'b0; a.pix_vld_i = 1'b0; a.pix_dat_i = '0; a.dn_rdy_i = 1'b0;
        b.sof_i = 1'b0; b.pix_vld_i = 1'b0; b.pix_dat_i = '0; b.dn_rdy_i = 1'b0;
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a_rdy", 32'(a.pix_rdy_o), 32'd0);
        chk("rst_a_wr_en", 32'(a.wr_en_o), 32'd0);
        chk("rst_a_rd", {a.rd_en_o, a.rd_double_flg_o, a.cl_en_o}, 32'd0);
        chk("rst_a_misc", {a.frame_done_o, a.err_o, a.trow_o}, 32'd0);
        chk("rst_a_addr", {a.rd_addr_o, a.wr_addr_o, a.dat_o}, 32'd0);
        chk("rst_b_all", {b.pix_rdy_o, b.wr_en_o, b.rd_en_o, b.rd_double_flg_o,
                          b.cl_en_o, b.frame_done_o, b.err_o, b.trow_o}, 32'd0);
        rstn = 1'b1;

        // frame on dut_a, tile row 0: mid-frame sof and a 10-cycle downstream stall
        @(negedge clk);
        a.sof_i = 1'b1;
        @(negedge clk);
        a.sof_i = 1'b0;
        chk("a_sof_rdy", 32'(a.pix_rdy_o), 32'd1);
        chk("a_sof_err", 32'(a.err_o), 32'd0);
        chk("a_sof_wr_en", 32'(a.wr_en_o), 32'd0);
        a_row(0);
        chk("a_row0_err", 32'(a.err_o), 32'd1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("a_stall_rd_en", 32'(a.rd_en_o), 32'd0);
            chk("a_stall_addr", 32'(a.rd_addr_o), 32'd0);
            chk("a_stall_dbl", 32'(a.rd_double_flg_o), 32'd1);
            chk("a_stall_rdy", 32'(a.pix_rdy_o), 32'd0);
        end
        a.dn_rdy_i = 1'b1;
        #1;
        chk("a_resume_en", 32'(a.rd_en_o), 32'd1);
        chk("a_resume_addr", 32'(a.rd_addr_o), 32'd0);
        @(negedge clk);
        chk("a_rd1_en", 32'(a.rd_en_o), 32'd1);
        chk("a_rd1_addr", 32'(a.rd_addr_o), 32'd2);
        chk("a_rd1_dbl", 32'(a.rd_double_flg_o), 32'd1);
        a_clear(32'd0);
        chk("a_trow1", 32'(a.trow_o), 32'd1);
        chk("a_acc2_rdy", 32'(a.pix_rdy_o), 32'd1);
        chk("a_err_sticky", 32'(a.err_o), 32'd1);

        // tile row 1 ends the frame
        a_row(1);
        a_reads();
        a_clear(32'd1);
        chk("a_frame_done", 32'(a.frame_done_o), 32'd1);
        chk("a_fd_rdy", 32'(a.pix_rdy_o), 32'd0);
        chk("a_fd_trow", 32'(a.trow_o), 32'd1);
        @(negedge clk);
        chk("a_fd_pulse", 32'(a.frame_done_o), 32'd0);
        chk("a_idle_rdy", 32'(a.pix_rdy_o), 32'd0);
        chk("a_idle_err", 32'(a.err_o), 32'd1);
        a.sof_i = 1'b1;
        @(negedge clk);
        a.sof_i = 1'b0;
        chk("a_err_clr", 32'(a.err_o), 32'd0);
        chk("a_new_rdy", 32'(a.pix_rdy_o), 32'd1);
        chk("a_new_trow", 32'(a.trow_o), 32'd0);

        // reset asserted during CLEAR
        a_row(2);
        a_reads();
        @(negedge clk);
        chk("a_cl_pre_rst", 32'(a.cl_en_o), 32'd1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("a_rst_cl_en", 32'(a.cl_en_o), 32'd0);
        chk("a_rst_rdy", 32'(a.pix_rdy_o), 32'd0);
        chk("a_rst_misc", {a.wr_en_o, a.rd_en_o, a.frame_done_o, a.err_o}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        a.pix_vld_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_idle_stall_rdy", 32'(a.pix_rdy_o), 32'd0);
        chk("a_idle_cl_en", 32'(a.cl_en_o), 32'd0);
`ifdef CHE_HIST_SCH_PERF_EN
        chk("a_stall_cnt", 32'(a.stall_cnt_o), 32'd3);
`endif
        a.pix_vld_i = 1'b0;
        a.sof_i = 1'b1;
        @(negedge clk);
        a.sof_i = 1'b0;
        chk("a_post_rst_rdy", 32'(a.pix_rdy_o), 32'd1);
`ifdef CHE_HIST_SCH_PERF_EN
        chk("a_stall_cnt_clr", 32'(a.stall_cnt_o), 32'd0);
`endif

        // dut_b: odd tile count, single tile row, sof colliding with frame_done
        b.sof_i = 1'b1;
        @(negedge clk);
        b.sof_i = 1'b0;
        b.dn_rdy_i = 1'b1;
        chk("b_sof_rdy", 32'(b.pix_rdy_o), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                chk("b_wr_en", 32'(b.wr_en_o), 32'd1);
                chk("b_wr_addr", 32'(b.wr_addr_o), 32'(((i - 1) % 10) / 2));
                chk("b_dat", 32'(b.dat_o), 32'(8'hA0 + i - 1));
            end
            b.pix_vld_i = 1'b1;
            b.pix_dat_i = 8'(8'hA0 + i);
            @(negedge clk);
        end
        b.pix_vld_i = 1'b0;
        chk("b_drain_wr_addr", 32'(b.wr_addr_o), 32'd4);
        chk("b_drain_dat", 32'(b.dat_o), 32'hB3);
        chk("b_drain_rd_en", 32'(b.rd_en_o), 32'd0);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("b_rd_en", 32'(b.rd_en_o), 32'd1);
            chk("b_rd_addr", 32'(b.rd_addr_o), 32'(2 * r));
            chk("b_rd_dbl", 32'(b.rd_double_flg_o), (r < 2) ? 32'd1 : 32'd0);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("b_cl_en", 32'(b.cl_en_o), 32'd1);
            chk("b_cl_rd_en", 32'(b.rd_en_o), 32'd0);
        end
        @(negedge clk);
        chk("b_cl_done", 32'(b.cl_en_o), 32'd0);
        chk("b_frame_done", 32'(b.frame_done_o), 32'd1);
        chk("b_fd_err", 32'(b.err_o), 32'd0);
        b.sof_i = 1'b1;
        @(negedge clk);
        b.sof_i = 1'b0;
        chk("b_fd_sof_err", 32'(b.err_o), 32'd1);
        chk("b_fd_sof_rdy", 32'(b.pix_rdy_o), 32'd0);
        chk("b_fd_pulse", 32'(b.frame_done_o), 32'd0);
        b.sof_i = 1'b1;
        @(negedge clk);
        b.sof_i = 1'b0;
        chk("b_err_clr", 32'(b.err_o), 32'd0);
        chk("b_restart_rdy", 32'(b.pix_rdy_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
